bmi_alu_seq: RTL and testbench



---
 rtl/bmi_alu_seq_if.sv | 25 ++
 rtl/bmi_alu_seq.sv | 228 ++++++++++++++++++++++
 tb/tb_bmi_alu_seq.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/bmi_alu_seq_if.sv
// Handshake and data bundle for bmi_alu_seq: operation request in, result out.
// The producer/consumer side uses master; the ALU itself uses slave.
interface bmi_alu_seq_if #(
    parameter int DATA_WIDTH = 256
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            opcode;
    logic [DATA_WIDTH-1:0] A_in;
    logic [DATA_WIDTH-1:0] B_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] Alu_out;
    logic                  err;

    modport master (
        output in_valid, opcode, A_in, B_in, out_ready,
        input  in_ready, out_valid, Alu_out, err
    );

    modport slave (
        input  in_valid, opcode, A_in, B_in, out_ready,
        output in_ready, out_valid, Alu_out, err
    );
endinterface

// File: rtl/bmi_alu_seq.sv
// Sequential bit-manipulation ALU: rotates and bit-reverse finish on the accept
// edge; parity, popcount, clz and ctz scan one CHUNK_WIDTH slice per cycle.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operation
// EXEC  | scanning chunk idx_q of a count operation
// DONE  | result valid, held until out_ready
module bmi_alu_seq #(
    parameter int DATA_WIDTH  = 256,
    parameter int CHUNK_WIDTH = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    bmi_alu_seq_if.slave  bus
);
    localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
    localparam int CNT_W      = $clog2(DATA_WIDTH + 1);
    localparam int SH_W       = $clog2(DATA_WIDTH);
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    generate
        if (DATA_WIDTH < 8 || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0) begin : g_bad_dw
            $error("bmi_alu_seq: DATA_WIDTH must be a power of two >= 8");
        end
        if (CHUNK_WIDTH < 1 || (CHUNK_WIDTH & (CHUNK_WIDTH - 1)) != 0 ||
            (DATA_WIDTH % CHUNK_WIDTH) != 0) begin : g_bad_cw
            $error("bmi_alu_seq: CHUNK_WIDTH must be a power of two dividing DATA_WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        OP_PARITY = 3'b000,
        OP_ROTR   = 3'b001,
        OP_ROTL   = 3'b010,
        OP_POPCNT = 3'b011,
        OP_CLZ    = 3'b100,
        OP_CTZ    = 3'b101,
        OP_BREV   = 3'b110,
        OP_ILL    = 3'b111
    } op_e;

    state_e                state_q;
    op_e                   op_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [IDX_W-1:0]      idx_q;
    logic [CNT_W-1:0]      acc_q;
    logic                  found_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  err_q;
    logic                  out_valid_q;

    // ---------------- single-cycle datapath (operates on live inputs) ----------------
    logic [SH_W-1:0]         amt;
    logic [2*DATA_WIDTH-1:0] dbl;
    logic [2*DATA_WIDTH-1:0] rotr_w;
    logic [2*DATA_WIDTH-1:0] rotl_w;
    logic [DATA_WIDTH-1:0]   brev_w;
    op_e                     op_in;

    assign op_in  = op_e'(bus.opcode);
    assign amt    = bus.B_in[SH_W-1:0];
    assign dbl    = {bus.A_in, bus.A_in};
    assign rotr_w = dbl >> amt;
    assign rotl_w = dbl << amt;

    always_comb begin
        brev_w = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            brev_w[i] = bus.A_in[DATA_WIDTH-1-i];
        end
    end

    // ---------------- chunked count datapath ----------------
    logic [IDX_W-1:0]       sel;
    logic [DATA_WIDTH-1:0]  a_sh;
    logic [CHUNK_WIDTH-1:0] chunk;
    logic [CNT_W-1:0]       chunk_pop;
    logic [CNT_W-1:0]       chunk_clz;
    logic [CNT_W-1:0]       chunk_ctz;
    logic                   chunk_nz;
    logic [CNT_W-1:0]       acc_d;
    logic                   found_d;
    logic                   last_chunk;

    // CLZ walks from the MSB chunk down, every other count op from the LSB chunk up
    assign sel        = (op_q == OP_CLZ) ? (IDX_W'(NUM_CHUNKS - 1) - idx_q) : idx_q;
    assign a_sh       = a_q >> (int'(sel) * CHUNK_WIDTH);
    assign chunk      = a_sh[CHUNK_WIDTH-1:0];
    assign chunk_nz   = |chunk;
    assign last_chunk = (idx_q == IDX_W'(NUM_CHUNKS - 1));

    always_comb begin
        chunk_pop = '0;
        chunk_clz = '0;
        chunk_ctz = '0;
        for (int i = 0; i < CHUNK_WIDTH; i++) begin
            chunk_pop = chunk_pop + CNT_W'(chunk[i]);
            if (chunk[i]) begin
                chunk_clz = CNT_W'(CHUNK_WIDTH - 1 - i);
            end
        end
        for (int i = CHUNK_WIDTH - 1; i >= 0; i--) begin
            if (chunk[i]) begin
                chunk_ctz = CNT_W'(i);
            end
        end
    end

    // Zero chunks before the first set bit add a full chunk width, so A=0 ends at DATA_WIDTH
    always_comb begin
        acc_d   = acc_q;
        found_d = found_q;
        case (op_q)
            OP_POPCNT: acc_d = acc_q + chunk_pop;
            OP_PARITY: acc_d = {acc_q[CNT_W-1:1], acc_q[0] ^ (^chunk)};
            OP_CLZ: begin
                if (!found_q) begin
                    if (chunk_nz) begin
                        acc_d   = acc_q + chunk_clz;
                        found_d = 1'b1;
                    end else begin
                        acc_d = acc_q + CNT_W'(CHUNK_WIDTH);
                    end
                end
            end
            OP_CTZ: begin
                if (!found_q) begin
                    if (chunk_nz) begin
                        acc_d   = acc_q + chunk_ctz;
                        found_d = 1'b1;
                    end else begin
                        acc_d = acc_q + CNT_W'(CHUNK_WIDTH);
                    end
                end
            end
            default: ;
        endcase
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= OP_PARITY;
            a_q         <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            found_q     <= 1'b0;
            result_q    <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_q    <= op_in;
                        a_q     <= bus.A_in;
                        idx_q   <= '0;
                        acc_q   <= '0;
                        found_q <= 1'b0;
                        case (op_in)
                            OP_ROTR: begin
                                result_q    <= rotr_w[DATA_WIDTH-1:0];
                                err_q       <= 1'b0;
                                out_valid_q <= 1'b1;
                                state_q     <= DONE;
                            end
                            OP_ROTL: begin
                                result_q    <= rotl_w[2*DATA_WIDTH-1:DATA_WIDTH];
                                err_q       <= 1'b0;
                                out_valid_q <= 1'b1;
                                state_q     <= DONE;
                            end
                            OP_BREV: begin
                                result_q    <= brev_w;
                                err_q       <= 1'b0;
                                out_valid_q <= 1'b1;
                                state_q     <= DONE;
                            end
                            OP_ILL: begin
                                result_q    <= '0;
                                err_q       <= 1'b1;
                                out_valid_q <= 1'b1;
                                state_q     <= DONE;
                            end
                            default: begin
                                state_q <= EXEC;
                            end
                        endcase
                    end
                end
                EXEC: begin
                    acc_q   <= acc_d;
                    found_q <= found_d;
                    idx_q   <= idx_q + IDX_W'(1);
                    if (last_chunk) begin
                        result_q    <= DATA_WIDTH'(acc_d);
                        err_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE) && rst_n;
    assign bus.out_valid = out_valid_q;
    assign bus.Alu_out   = result_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_bmi_alu_seq.sv
// Directed bench for bmi_alu_seq at DATA_WIDTH=256, CHUNK_WIDTH=64.
// Inputs change and outputs are sampled on the falling edge.
module tb_bmi_alu_seq;
    localparam int DW = 256;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    bmi_alu_seq_if #(.DATA_WIDTH(DW)) bus();

    bmi_alu_seq #(.DATA_WIDTH(DW), .CHUNK_WIDTH(64)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not reach its summary");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation, wait for its result, check it, then pop it.
    task automatic do_op(input string tag, input logic [2:0] opc, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [DW-1:0] exp_res,
                         input logic exp_err, input int exp_busy);
        int busy;
        int ir_hi;
        @(negedge clk);
        chk({tag, " in_ready"}, DW'(bus.in_ready), DW'(1));
        bus.in_valid = 1'b1;
        bus.opcode   = opc;
        bus.A_in     = a;
        bus.B_in     = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.opcode   = opc ^ 3'b011;
        bus.A_in     = ~a;
        bus.B_in     = ~b;
        busy  = 0;
        ir_hi = 0;
        while (bus.out_valid !== 1'b1 && busy < 20) begin
            if (bus.in_ready !== 1'b0) ir_hi++;
            busy++;
            @(negedge clk);
        end
        chk({tag, " busy_cycles"}, DW'(busy), DW'(exp_busy));
        chk({tag, " ready_while_busy"}, DW'(ir_hi), DW'(0));
        chk({tag, " result"}, bus.Alu_out, exp_res);
        chk({tag, " err"}, DW'(bus.err), DW'(exp_err));
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, " out_valid_after_pop"}, DW'(bus.out_valid), DW'(0));
    endtask

    logic [DW-1:0] ones;
    logic [DW-1:0] one;
    int stable_bad, ir_bad, ov_bad, busy_cnt;

    initial begin
        ones          = '1;
        one           = DW'(1);
        bus.in_valid  = 1'b0;
        bus.opcode    = 3'b000;
        bus.A_in      = '0;
        bus.B_in      = '0;
        bus.out_ready = 1'b0;

        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst in_ready", DW'(bus.in_ready), DW'(0));
        chk("rst out_valid", DW'(bus.out_valid), DW'(0));
        chk("rst Alu_out", bus.Alu_out, '0);
        chk("rst err", DW'(bus.err), DW'(0));
        rst_n = 1'b1;

        // opcode map: 000 PAR, 001 ROTR, 010 ROTL, 011 POP, 100 CLZ, 101 CTZ, 110 BREV
        do_op("popcnt_ones", 3'b011, ones, '0, DW'(256), 1'b0, 4);
        do_op("popcnt_f0f0", 3'b011, DW'(16'hF0F0), '0, DW'(8), 1'b0, 4);
        do_op("rotr_1_1", 3'b001, one, DW'(1), one << 255, 1'b0, 0);
        do_op("rotl_1_257", 3'b010, one, DW'(257), DW'(2), 1'b0, 0);
        do_op("rotl_amt0", 3'b010, DW'(32'hDEADBEEF), '0, DW'(32'hDEADBEEF), 1'b0, 0);
        do_op("clz_zero", 3'b100, '0, '0, DW'(256), 1'b0, 4);
        do_op("clz_bit200", 3'b100, one << 200, '0, DW'(55), 1'b0, 4);
        do_op("ctz_0x100", 3'b101, DW'(12'h100), '0, DW'(8), 1'b0, 4);
        do_op("ctz_zero", 3'b101, '0, '0, DW'(256), 1'b0, 4);
        do_op("ctz_bit130", 3'b101, (one << 130) | (one << 250), '0, DW'(130), 1'b0, 4);
        do_op("parity_7", 3'b000, DW'(3'h7), '0, DW'(1), 1'b0, 4);
        do_op("parity_3", 3'b000, DW'(2'h3), '0, DW'(0), 1'b0, 4);
        do_op("brev_1", 3'b110, one, '0, one << 255, 1'b0, 0);

        // backpressure: result held 10 cycles while inputs churn
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.opcode   = 3'b011;
        bus.A_in     = DW'(8'hFF);
        @(negedge clk);
        busy_cnt = 0;
        while (bus.out_valid !== 1'b1 && busy_cnt < 20) begin
            bus.A_in   = {8{$urandom}};
            bus.opcode = 3'($urandom_range(0, 7));
            busy_cnt++;
            @(negedge clk);
        end
        chk("bp busy_cycles", DW'(busy_cnt), DW'(4));
        stable_bad = 0;
        ir_bad     = 0;
        ov_bad     = 0;
        for (int i = 0; i < 10; i++) begin
            bus.A_in   = {8{$urandom}};
            bus.opcode = 3'(i);
            @(negedge clk);
            if (bus.Alu_out !== DW'(8)) stable_bad++;
            if (bus.in_ready !== 1'b0) ir_bad++;
            if (bus.out_valid !== 1'b1) ov_bad++;
        end
        chk("bp result", bus.Alu_out, DW'(8));
        chk("bp err", DW'(bus.err), DW'(0));
        chk("bp result_unstable", DW'(stable_bad), DW'(0));
        chk("bp ready_while_held", DW'(ir_bad), DW'(0));
        chk("bp valid_dropped", DW'(ov_bad), DW'(0));
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("bp out_valid_after_pop", DW'(bus.out_valid), DW'(0));
        chk("bp in_ready_after_pop", DW'(bus.in_ready), DW'(1));

        // reset in the middle of a popcount scan
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.opcode   = 3'b011;
        bus.A_in     = ones;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort out_valid", DW'(bus.out_valid), DW'(0));
        chk("abort Alu_out", bus.Alu_out, '0);
        chk("abort in_ready", DW'(bus.in_ready), DW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        ov_bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) ov_bad++;
        end
        chk("abort stale_valid", DW'(ov_bad), DW'(0));
        chk("abort in_ready_after", DW'(bus.in_ready), DW'(1));

        do_op("rotl_msb_1", 3'b010, one << 255, DW'(1), one, 1'b0, 0);
        do_op("illegal", 3'b111, ones, ones, '0, 1'b1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
